// File: rtl/network_cfg_loader_pkg.sv
// Shared sizing and FSM state type for the permutation-network configuration loader.
package FHE_ALU_PKG;

  localparam int STAGE_NUM  = 9;
  localparam int SWITCH_NUM = 256;

  localparam int               CNT_W      = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(STAGE_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_FILL        = 2'd1,
    S_COMMIT_WAIT = 2'd2
  } net_cfg_state_t;

endpackage

// File: rtl/network_cfg_loader_bank.sv
// Two-bank switch-control register file: one stage write port, per-stage bank-selected read.
module net_cfg_bank
  import FHE_ALU_PKG::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic                  i_wbank,
  input  logic [CNT_W-1:0]      i_wstage,
  input  logic [SWITCH_NUM-1:0] i_wdata,
  input  logic [STAGE_NUM-1:0]  i_rbank,
  output logic [SWITCH_NUM-1:0] o_rdata [0:STAGE_NUM-1]
);

  logic [SWITCH_NUM-1:0] r_mem [0:1][0:STAGE_NUM-1];

  // All-zero switches are pass-through, so reset leaves the network transparent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < STAGE_NUM; s++) begin
          r_mem[b][s] <= '0;
        end
      end
    end else if (i_we) begin
      r_mem[i_wbank][i_wstage] <= i_wdata;
    end
  end

  always_comb begin
    for (int s = 0; s < STAGE_NUM; s++) begin
      o_rdata[s] = r_mem[i_rbank[s]][s];
    end
  end

endmodule

// File: rtl/network_cfg_loader.sv
// Double-buffered permutation-network configuration loader with traffic-safe bank swap.
// Optional macro NET_CFG_STAGE_ALIGN_EN: per-stage bank tags allow swapping under traffic.
module network_cfg_loader
  import FHE_ALU_PKG::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SWITCH_NUM-1:0] cfg_word,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_last,
  input  logic                  net_valid,
  output logic [SWITCH_NUM-1:0] switch_set [0:STAGE_NUM-1],
  output logic                  active_bank,
  output logic                  swap_pulse,
  output logic                  cfg_err,
  output logic                  busy
);

  net_cfg_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [STAGE_NUM:0]   r_vld;
  logic                 r_active, r_swap_pulse, r_err;
  logic                 w_accept, w_at_end, w_swap_ok, w_swap, w_err_set;
  logic [STAGE_NUM-1:0] w_rbank;

  assign w_accept = cfg_valid && cfg_ready;
  assign w_at_end = (r_cnt == LAST_STAGE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_FILL: begin
        if (w_accept) begin
          if (cfg_last && w_at_end)      w_state_nxt = S_COMMIT_WAIT;
          else if (cfg_last || w_at_end) w_state_nxt = S_IDLE;
          else                           w_state_nxt = S_FILL;
        end
      end
      S_COMMIT_WAIT: if (w_swap_ok) w_state_nxt = S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (r_state != S_COMMIT_WAIT);
    busy      = (r_state != S_IDLE);
    w_swap    = (r_state == S_COMMIT_WAIT) && w_swap_ok;
    // Early cfg_last or a missing one at the final stage both abort the load.
    w_err_set = w_accept && (cfg_last != w_at_end);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_active     <= 1'b0;
      r_swap_pulse <= 1'b0;
      r_err        <= 1'b0;
      r_vld        <= '0;
    end else begin
      if (w_state_nxt != S_FILL) r_cnt <= '0;
      else if (w_accept)         r_cnt <= r_cnt + 1'b1;
      if (w_swap) r_active <= ~r_active;
      r_swap_pulse <= w_swap;
      r_err        <= r_err | w_err_set;
      r_vld        <= {r_vld[STAGE_NUM-1:0], net_valid};
    end
  end

`ifdef NET_CFG_STAGE_ALIGN_EN
  // Each in-flight vector carries the bank it entered with, so it finishes on that bank.
  logic [STAGE_NUM:0] r_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tag <= '0;
    else     r_tag <= {r_tag[STAGE_NUM-1:0], r_active};
  end

  assign w_swap_ok = 1'b1;

  always_comb begin
    for (int k = 0; k < STAGE_NUM; k++) begin
      w_rbank[k] = r_vld[k] ? r_tag[k] : r_active;
    end
  end
`else
  assign w_swap_ok = (r_vld == '0) && !net_valid;
  assign w_rbank   = {STAGE_NUM{r_active}};
`endif

  net_cfg_bank u_bank (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_accept),
    .i_wbank  (~r_active),
    .i_wstage (r_cnt),
    .i_wdata  (cfg_word),
    .i_rbank  (w_rbank),
    .o_rdata  (switch_set)
  );

  assign active_bank = r_active;
  assign swap_pulse  = r_swap_pulse;
  assign cfg_err     = r_err;

endmodule
